// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// CPU side: 16-bit word port with a held request and a single-cycle mem_resp.
// Memory side: 128-bit line port with a held request and pmem_resp.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | serve hits combinationally; on a miss pick writeback or fill
// WRITEBACK | dirty victim line being written to physical memory
// ALLOCATE  | requested line being fetched from physical memory
module l1_dcache_dm #(
   parameter int INDEX_BITS = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [1:0]    mem_byte_enable,
   input  logic [15:0]   mem_address,
   input  logic [15:0]   mem_wdata,
   output logic [15:0]   mem_rdata,
   output logic          mem_resp,
   output logic          pmem_read,
   output logic          pmem_write,
   output logic [15:0]   pmem_address,
   output logic [127:0]  pmem_wdata,
   input  logic [127:0]  pmem_rdata,
   input  logic          pmem_resp
);
   localparam int SETS     = 2 ** INDEX_BITS;
   localparam int TAG_BITS = 12 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [127:0]          data_arr [SETS];
   logic [TAG_BITS-1:0]   tag_arr  [SETS];
   logic [SETS-1:0]       valid_bits;
   logic [SETS-1:0]       dirty_bits;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic [2:0]            word_sel;
   logic [127:0]          cur_line;
   logic                  req;
   logic                  hit;
   logic                  unused_addr_bit;

   assign idx             = mem_address[3+INDEX_BITS:4];
   assign req_tag         = mem_address[15:4+INDEX_BITS];
   assign word_sel        = mem_address[3:1];
   // Byte lane selection is the CPU's responsibility, so bit 0 plays no part.
   assign unused_addr_bit = mem_address[0];
   assign cur_line        = data_arr[idx];
   assign req             = mem_read | mem_write;
   assign hit             = valid_bits[idx] & (tag_arr[idx] == req_tag);
   assign mem_rdata       = cur_line[{word_sel, 4'b0000} +: 16];
   assign pmem_wdata      = cur_line;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: a dropped request still lets the in-flight line transfer
   // finish, but skips the fill after a writeback.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               if (valid_bits[idx] && dirty_bits[idx]) state_nxt = WRITEBACK;
               else                                    state_nxt = ALLOCATE;
            end
         end
         WRITEBACK: begin
            if (pmem_resp) state_nxt = req ? ALLOCATE : IDLE;
         end
         ALLOCATE: begin
            if (pmem_resp) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: hits answer in IDLE; victim address uses the stored tag.
   always_comb begin
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = {req_tag, idx, 4'b0000};
      case (state)
         IDLE:      mem_resp = req & hit;
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_arr[idx], idx, 4'b0000};
         end
         ALLOCATE:  pmem_read = 1'b1;
         default:   ;
      endcase
   end

   // Array updates: write-hit byte merge, dirty clear after writeback, line fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_write && hit) begin
                  if (mem_byte_enable[0])
                     data_arr[idx][{word_sel, 4'b0000} +: 8] <= mem_wdata[7:0];
                  if (mem_byte_enable[1])
                     data_arr[idx][{word_sel, 4'b1000} +: 8] <= mem_wdata[15:8];
                  if (|mem_byte_enable) dirty_bits[idx] <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (pmem_resp) dirty_bits[idx] <= 1'b0;
            end
            ALLOCATE: begin
               if (pmem_resp) begin
                  data_arr[idx]   <= pmem_rdata;
                  tag_arr[idx]    <= req_tag;
                  valid_bits[idx] <= 1'b1;
                  dirty_bits[idx] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_dcache_dm.sv
// Directed bench for l1_dcache_dm with a physical-memory responder model.
// Expected CPU responses and expected line transactions are queued by the
// stimulus and consumed by independent monitor processes.
module tb_l1_dcache_dm;
   localparam int PM_LAT = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_read;
   logic          mem_write;
   logic [1:0]    mem_byte_enable;
   logic [15:0]   mem_address;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata;
   logic          mem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [15:0]   pmem_address;
   logic [127:0]  pmem_wdata;
   logic [127:0]  pmem_rdata;
   logic          pmem_resp;

   typedef struct {
      bit          chk;
      logic [15:0] data;
   } cpu_t;

   typedef struct {
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } pm_t;

   cpu_t exp_cpu[$];
   pm_t  exp_pm[$];
   logic [127:0] pm_mem [logic [15:0]];

   int errors = 0;
   int checks = 0;
   int pw_cycles = 0;
   bit hold_pmem = 1'b0;

   l1_dcache_dm #(.INDEX_BITS(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [127:0] get_line(input logic [15:0] a);
      if (pm_mem.exists(a)) return pm_mem[a];
      return {8{a}};
   endfunction

   task automatic push_pm(input bit wr, input logic [15:0] a, input logic [127:0] d);
      pm_t e;
      e.wr = wr;
      e.addr = a;
      e.wdata = d;
      exp_pm.push_back(e);
   endtask

   // Physical memory: answers PM_LAT cycles after a strobe is seen, checks each
   // transaction against the expected queue and keeps the backing store current.
   initial begin
      int wait_cnt;
      pm_t e;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (pmem_read || pmem_write)
            chk("pmem_exclusive", {127'b0, pmem_read & pmem_write}, 128'd0);
         if (pmem_write) pw_cycles++;
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            wait_cnt = 0;
         end else if (reset || hold_pmem || !(pmem_read || pmem_write)) begin
            wait_cnt = 0;
         end else if (wait_cnt < PM_LAT) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            if (exp_pm.size() == 0) begin
               fail_now("pmem_unexpected_transaction");
            end else begin
               e = exp_pm.pop_front();
               chk("pmem_op_is_write", {127'b0, pmem_write}, {127'b0, e.wr});
               chk("pmem_address", {112'b0, pmem_address}, {112'b0, e.addr});
               if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
            end
            if (pmem_write) pm_mem[pmem_address] = pmem_wdata;
            else            pmem_rdata = get_line(pmem_address);
            pmem_resp = 1'b1;
         end
      end
   end

   // CPU-side monitor.
   initial begin
      cpu_t c;
      forever begin
         @(negedge clk);
         if (mem_resp && !reset) begin
            chk("resp_has_req", {127'b0, mem_read | mem_write}, 128'd1);
            if (exp_cpu.size() == 0) begin
               fail_now("cpu_unexpected_resp");
            end else begin
               c = exp_cpu.pop_front();
               if (c.chk) chk("mem_rdata", {112'b0, mem_rdata}, {112'b0, c.data});
            end
         end
      end
   end

   // hit_mode: 1 = must answer in the request cycle, 0 = must miss, 2 = either.
   task automatic cpu_op(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic [15:0] exp, input int hit_mode);
      cpu_t c;
      int n;
      bit done;
      c.chk = !wr;
      c.data = exp;
      exp_cpu.push_back(c);
      @(posedge clk); #1;
      mem_read = rd;
      mem_write = wr;
      mem_address = a;
      mem_wdata = wd;
      mem_byte_enable = be;
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         if (mem_resp) done = 1'b1;
         else n++;
      end
      if (!done) begin
         fail_now("cpu_resp_timeout");
         if (exp_cpu.size() > 0) void'(exp_cpu.pop_back());
      end else if (hit_mode == 1) begin
         chk("hit_same_cycle", {127'b0, n == 0}, 128'd1);
      end else if (hit_mode == 0) begin
         chk("miss_delayed", {127'b0, n > 0}, 128'd1);
      end
      @(posedge clk); #1;
      mem_read = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic wait_pmem_read();
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (pmem_read) break;
      end
      chk("pmem_read_seen", {127'b0, pmem_read}, 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int pw_before;
      reset = 1'b1;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_byte_enable = 2'b00;
      mem_address = 16'h0;
      mem_wdata = 16'h0;
      pmem_rdata = '0;
      pmem_resp = 1'b0;
      pm_mem[16'h0100] = 128'h7777_6666_5555_4444_3333_2222_BEEF_0000;
      pm_mem[16'h0900] = 128'h9907_9906_9905_9904_9903_9902_9901_9900;
      pm_mem[16'h0210] = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_resp", {127'b0, mem_resp}, 128'd0);
      chk("reset_pmem_read", {127'b0, pmem_read}, 128'd0);
      chk("reset_pmem_write", {127'b0, pmem_write}, 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Cold read, then repeat as a hit.
      push_pm(1'b0, 16'h0100, '0);
      cpu_op(1'b0, 1'b1, 16'h0102, 16'h0, 2'b00, 16'hBEEF, 0);
      cpu_op(1'b0, 1'b1, 16'h0102, 16'h0, 2'b00, 16'hBEEF, 1);

      // Low-byte write hit, read back merged word.
      cpu_op(1'b1, 1'b0, 16'h0104, 16'h1234, 2'b01, 16'h0, 1);
      cpu_op(1'b0, 1'b1, 16'h0104, 16'h0, 2'b00, 16'h2234, 1);

      // Dirty conflict miss: writeback merged line, then fill.
      push_pm(1'b1, 16'h0100, 128'h7777_6666_5555_4444_3333_2234_BEEF_0000);
      push_pm(1'b0, 16'h0900, '0);
      cpu_op(1'b0, 1'b1, 16'h0904, 16'h0, 2'b00, 16'h9902, 0);

      // Clean conflict miss: fill only.
      pw_before = pw_cycles;
      push_pm(1'b0, 16'h0100, '0);
      cpu_op(1'b0, 1'b1, 16'h0102, 16'h0, 2'b00, 16'hBEEF, 0);
      chk("clean_miss_no_writeback", pw_cycles - pw_before, 128'd0);

      // Write-allocate on set 1 with high-byte write, then full-word write.
      push_pm(1'b0, 16'h0210, '0);
      cpu_op(1'b1, 1'b0, 16'h0216, 16'hCAFE, 2'b10, 16'h0, 0);
      cpu_op(1'b0, 1'b1, 16'h0216, 16'h0, 2'b00, 16'hCAA3, 1);
      cpu_op(1'b1, 1'b0, 16'h0210, 16'h5A5A, 2'b11, 16'h0, 1);
      cpu_op(1'b0, 1'b1, 16'h0210, 16'h0, 2'b00, 16'h5A5A, 1);
      push_pm(1'b1, 16'h0210, 128'hA7A7_A6A6_A5A5_A4A4_CAA3_A2A2_A1A1_5A5A);
      push_pm(1'b0, 16'h0A10, '0);
      cpu_op(1'b0, 1'b1, 16'h0A10, 16'h0, 2'b00, 16'h0A10, 0);

      // Read and write together behave as a write.
      cpu_op(1'b1, 1'b1, 16'h0A12, 16'h1111, 2'b11, 16'h0, 1);
      cpu_op(1'b0, 1'b1, 16'h0A12, 16'h0, 2'b00, 16'h1111, 1);

      // Request dropped while the fill is outstanding.
      push_pm(1'b0, 16'h0540, '0);
      @(posedge clk); #1;
      mem_read = 1'b1;
      mem_address = 16'h0540;
      wait_pmem_read();
      @(posedge clk); #1;
      mem_read = 1'b0;
      repeat (6) @(negedge clk);
      chk("drop_fill_completed", exp_pm.size(), 128'd0);
      chk("drop_back_to_idle", {127'b0, pmem_read | pmem_write}, 128'd0);
      cpu_op(1'b0, 1'b1, 16'h0540, 16'h0, 2'b00, 16'h0540, 1);

      // Reset while a fill is pending.
      hold_pmem = 1'b1;
      @(posedge clk); #1;
      mem_read = 1'b1;
      mem_address = 16'h0324;
      wait_pmem_read();
      @(posedge clk); #1;
      reset = 1'b1;
      mem_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("reset_abort_pmem_read", {127'b0, pmem_read}, 128'd0);
      chk("reset_abort_mem_resp", {127'b0, mem_resp}, 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      hold_pmem = 1'b0;
      push_pm(1'b0, 16'h0320, '0);
      cpu_op(1'b0, 1'b1, 16'h0324, 16'h0, 2'b00, 16'h0320, 0);
      push_pm(1'b0, 16'h0100, '0);
      cpu_op(1'b0, 1'b1, 16'h0102, 16'h0, 2'b00, 16'hBEEF, 0);

      repeat (3) @(negedge clk);
      chk("cpu_queue_drained", exp_cpu.size(), 128'd0);
      chk("pmem_queue_drained", exp_pm.size(), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
